uart_serial_tx: RTL and testbench

UART_SERIAL_TX -- requirements
Module: uart_serial_tx

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_baud_gen.sv | 38 +++
 rtl/uart_serial_tx.sv | 144 ++++++++++++++
 tb/tb_uart_serial_tx.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and line levels for the UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } tx_state_e;

    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time generator: bit_tick marks the last clk cycle of each bit period.
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] divisor,
    input  logic             restart,
    input  logic             enable,
    output logic             bit_tick
);

    logic [DIV_W-1:0] cnt_reg;
    logic [DIV_W-1:0] cnt_next;
    logic [DIV_W-1:0] reload;

    // Down-counter preloaded with divisor-1; a zero divisor behaves like one.
    assign reload   = (divisor == '0) ? '0 : divisor - DIV_W'(1);
    assign bit_tick = enable && !restart && (cnt_reg == '0);

    always_comb begin
        cnt_next = cnt_reg;
        if (restart) begin
            cnt_next = reload;
        end else if (enable) begin
            cnt_next = (cnt_reg == '0) ? reload : cnt_reg - DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/uart_serial_tx.sv
// UART transmitter: start, DATA_W bits LSB first, optional parity, 1 or 2 stops.
// Optional line-break support is enabled by defining UART_TX_BREAK_EN.
module uart_serial_tx
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIV_W-1:0]  divisor,
    input  logic              parity_en,
    input  logic              parity_odd,
    input  logic              stop2,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              sdata,
    output logic              busy
`ifdef UART_TX_BREAK_EN
    ,
    input  logic              break_req
`endif
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    tx_state_e         state_reg;
    tx_state_e         state_next;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_next;
    logic [IDX_W-1:0]  bit_idx_reg;
    logic [IDX_W-1:0]  bit_idx_next;
    logic [DIV_W-1:0]  div_reg;
    logic              par_en_reg;
    logic              par_bit_reg;
    logic              stop2_reg;

    logic              idle;
    logic              accept;
    logic              bit_tick;
    logic [DIV_W-1:0]  baud_div;

    assign idle   = (state_reg == IDLE);
    assign accept = tx_valid && tx_ready;

`ifdef UART_TX_BREAK_EN
    // Break only starts from IDLE, so a pending request waits out any frame.
    assign tx_ready = idle && !break_req;
    assign busy     = !idle || break_req;
`else
    assign tx_ready = idle;
    assign busy     = !idle;
`endif

    // The counter is reloaded on the accept edge, before div_reg holds the new value.
    assign baud_div = accept ? divisor : div_reg;

    uart_baud_gen #(
        .DIV_W(DIV_W)
    ) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .divisor (baud_div),
        .restart (accept),
        .enable  (!idle),
        .bit_tick(bit_tick)
    );

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_idx_next = bit_idx_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next   = START;
                    shift_next   = tx_data;
                    bit_idx_next = '0;
                end
            end
            START: begin
                if (bit_tick) state_next = DATA;
            end
            DATA: begin
                if (bit_tick) begin
                    shift_next = shift_reg >> 1;
                    if (bit_idx_reg == LAST_IDX) begin
                        state_next = par_en_reg ? PARITY : STOP1;
                    end else begin
                        bit_idx_next = bit_idx_reg + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_tick) state_next = STOP1;
            end
            STOP1: begin
                if (bit_tick) state_next = stop2_reg ? STOP2 : IDLE;
            end
            STOP2: begin
                if (bit_tick) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sdata = UART_IDLE_LVL;
        case (state_reg)
            START:   sdata = UART_START_LVL;
            DATA:    sdata = shift_reg[0];
            PARITY:  sdata = par_bit_reg;
            default: sdata = UART_IDLE_LVL;
        endcase
`ifdef UART_TX_BREAK_EN
        if (idle && break_req) sdata = UART_START_LVL;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_idx_reg <= '0;
            div_reg     <= '0;
            par_en_reg  <= 1'b0;
            par_bit_reg <= 1'b0;
            stop2_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_idx_reg <= bit_idx_next;
            if (accept) begin
                div_reg     <= divisor;
                par_en_reg  <= parity_en;
                par_bit_reg <= (^tx_data) ^ parity_odd;
                stop2_reg   <= stop2;
            end
        end
    end

endmodule

// File: tb/tb_uart_serial_tx.sv
// Scoreboard bench for uart_serial_tx: expected per-cycle {busy,sdata,tx_ready} queued at send time.
module tb_uart_serial_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] divisor = 16'd4;
    logic        parity_en = 1'b0;
    logic        parity_odd = 1'b0;
    logic        stop2 = 1'b0;
    logic        tx_valid = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_ready;
    logic        sdata;
    logic        busy;
`ifdef UART_TX_BREAK_EN
    logic        break_req = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    uart_serial_tx #(.DATA_W(8), .DIV_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .divisor   (divisor),
        .parity_en (parity_en),
        .parity_odd(parity_odd),
        .stop2     (stop2),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .sdata     (sdata),
        .busy      (busy)
`ifdef UART_TX_BREAK_EN
        ,
        .break_req (break_req)
`endif
    );

    // Expected frame cycles ({busy,sdata,ready}) followed by one idle cycle.
    task automatic push_frame(input logic [7:0] d, input int dv, input logic pe,
                              input logic pbit, input logic s2);
        logic lv[$];
        int   n;
        n = (dv == 0) ? 1 : dv;
        lv.push_back(1'b0);
        for (int i = 0; i < 8; i++) lv.push_back(d[i]);
        if (pe) lv.push_back(pbit);
        lv.push_back(1'b1);
        if (s2) lv.push_back(1'b1);
        foreach (lv[k]) begin
            for (int r = 0; r < n; r++) exp_q.push_back({1'b1, lv[k], 1'b0});
        end
        exp_q.push_back(3'b011);
    endtask

    // Called at a negedge; offers one character for exactly one edge.
    task automatic start_tx(input logic [7:0] d, input logic [15:0] dv, input logic pe,
                            input logic po, input logic s2);
        tx_data = d; divisor = dv; parity_en = pe; parity_odd = po; stop2 = s2;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if ({busy, sdata, tx_ready} !== 3'b011) begin
            errors++;
            $display("FAIL reset_state obs %b exp 011", {busy, sdata, tx_ready});
        end
        @(negedge clk);
        checks++;
        if ({busy, sdata, tx_ready} !== 3'b011) begin
            errors++;
            $display("FAIL reset_hold obs %b exp 011", {busy, sdata, tx_ready});
        end
        rst_n = 1'b1;
        $display("tx reset released");
    endtask

    // Starts in the very first cycle after reset release.
    task automatic test_basic;
        logic [2:0] e;
        int cyc = 0;
        push_frame(8'hA5, 4, 1'b0, 1'b0, 1'b0);
        start_tx(8'hA5, 16'd4, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({busy, sdata, tx_ready} !== e) begin
                errors++;
                $display("FAIL basic_a5 cyc %0d obs %b exp %b", cyc, {busy, sdata, tx_ready}, e);
            end
            cyc++;
        end
        $display("tx basic data=a5 div=4 cycles=%0d", cyc);
    endtask

    task automatic test_parity(input logic po, input logic pbit);
        logic [2:0] e;
        int cyc = 0;
        push_frame(8'h07, 4, 1'b1, pbit, 1'b0);
        start_tx(8'h07, 16'd4, 1'b1, po, 1'b0);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({busy, sdata, tx_ready} !== e) begin
                errors++;
                $display("FAIL parity_odd%0d cyc %0d obs %b exp %b", po, cyc, {busy, sdata, tx_ready}, e);
            end
            cyc++;
        end
        $display("tx parity data=07 odd=%0d cycles=%0d", po, cyc);
    endtask

    task automatic test_back_to_back;
        logic [2:0] e;
        int cyc = 0;
        int ready_cnt = 0;
        push_frame(8'h55, 1, 1'b0, 1'b0, 1'b1);
        push_frame(8'hAA, 1, 1'b0, 1'b0, 1'b1);
        tx_data = 8'h55; divisor = 16'd1; parity_en = 1'b0; stop2 = 1'b1;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_data = 8'hAA;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({busy, sdata, tx_ready} !== e) begin
                errors++;
                $display("FAIL back_to_back cyc %0d obs %b exp %b", cyc, {busy, sdata, tx_ready}, e);
            end
            if (tx_ready) ready_cnt++;
            if (cyc == 11) begin
                @(posedge clk);
                #1 tx_valid = 1'b0;
            end
            cyc++;
        end
        checks++;
        if (ready_cnt != 2) begin
            errors++;
            $display("FAIL b2b_ready_pulses obs %0d exp 2", ready_cnt);
        end
        $display("tx back_to_back 55,aa div=1 stop2 cycles=%0d", cyc);
    endtask

    task automatic test_divisor_zero;
        logic [2:0] e;
        int cyc = 0;
        push_frame(8'h3C, 1, 1'b0, 1'b0, 1'b0);
        start_tx(8'h3C, 16'd0, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({busy, sdata, tx_ready} !== e) begin
                errors++;
                $display("FAIL div_zero cyc %0d obs %b exp %b", cyc, {busy, sdata, tx_ready}, e);
            end
            cyc++;
        end
        $display("tx div_zero data=3c cycles=%0d", cyc);
    endtask

    // Inputs change mid-frame and a tx_valid burst while busy must leave no trace.
    task automatic test_midframe_change;
        logic [2:0] e;
        int cyc = 0;
        push_frame(8'h5A, 4, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(3'b011);
        exp_q.push_back(3'b011);
        start_tx(8'h5A, 16'd4, 1'b0, 1'b0, 1'b0);
        divisor = 16'd8; parity_en = 1'b1; stop2 = 1'b1; tx_data = 8'hFF;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({busy, sdata, tx_ready} !== e) begin
                errors++;
                $display("FAIL midframe_change cyc %0d obs %b exp %b", cyc, {busy, sdata, tx_ready}, e);
            end
            if (cyc == 5)  tx_valid = 1'b1;
            if (cyc == 30) tx_valid = 1'b0;
            cyc++;
        end
        $display("tx midframe_change data=5a div=4->8 cycles=%0d", cyc);
    endtask

    task automatic test_reset_midframe;
        logic [2:0] e;
        int cyc = 0;
        push_frame(8'hA5, 4, 1'b0, 1'b0, 1'b0);
        start_tx(8'hA5, 16'd4, 1'b0, 1'b0, 1'b0);
        // Data bit 3 of 0xA5 is 0 and occupies frame cycles 16..19.
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({busy, sdata, tx_ready} !== e) begin
                errors++;
                $display("FAIL pre_reset cyc %0d obs %b exp %b", c, {busy, sdata, tx_ready}, e);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, sdata, tx_ready} !== 3'b011) begin
            errors++;
            $display("FAIL async_reset obs %b exp 011", {busy, sdata, tx_ready});
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, sdata, tx_ready} !== 3'b011) begin
            errors++;
            $display("FAIL post_reset_idle obs %b exp 011", {busy, sdata, tx_ready});
        end
        push_frame(8'h81, 2, 1'b0, 1'b0, 1'b0);
        start_tx(8'h81, 16'd2, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({busy, sdata, tx_ready} !== e) begin
                errors++;
                $display("FAIL post_reset_frame cyc %0d obs %b exp %b", cyc, {busy, sdata, tx_ready}, e);
            end
            cyc++;
        end
        $display("tx reset_midframe then data=81 div=2 cycles=%0d", cyc);
    endtask

`ifdef UART_TX_BREAK_EN
    task automatic test_break;
        logic [2:0] e;
        int cyc = 0;
        break_req = 1'b1;
        tx_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if ({busy, sdata, tx_ready} !== 3'b100) begin
                errors++;
                $display("FAIL break_idle cyc %0d obs %b exp 100", c, {busy, sdata, tx_ready});
            end
        end
        break_req = 1'b0;
        tx_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, sdata, tx_ready} !== 3'b011) begin
            errors++;
            $display("FAIL break_release obs %b exp 011", {busy, sdata, tx_ready});
        end
        push_frame(8'h33, 2, 1'b0, 1'b0, 1'b0);
        exp_q[exp_q.size() - 1] = 3'b100;
        for (int c = 0; c < 4; c++) exp_q.push_back(3'b100);
        start_tx(8'h33, 16'd2, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({busy, sdata, tx_ready} !== e) begin
                errors++;
                $display("FAIL break_midframe cyc %0d obs %b exp %b", cyc, {busy, sdata, tx_ready}, e);
            end
            if (cyc == 3) break_req = 1'b1;
            cyc++;
        end
        break_req = 1'b0;
        $display("tx break idle=20 then midframe data=33 cycles=%0d", cyc);
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_parity(1'b0, 1'b1);
        test_parity(1'b1, 1'b0);
        test_back_to_back;
        test_divisor_zero;
        test_midframe_change;
        test_reset_midframe;
`ifdef UART_TX_BREAK_EN
        test_break;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
